div_unit: RTL and testbench

Iterative radix-2 divider for the execute stage. The execute stage decodes an RV32M divide or remainder instruction using the same 5-bit sub-opcode encoding as the ALU, then hands the two operands to this block instead of the ALU. The block computes the result over 32 iteration cycles and returns it with a one-cycle done pulse. Meanwhile the pipeline stalls on `busy`.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 190 +++++++++++++++++++
 tb/tb_div_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage and the iterative divider.
// The stage is the master; the divider is the slave.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       sub_opcode;
  logic [WIDTH-1:0] div_lhs;
  logic [WIDTH-1:0] div_rhs;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] div_result;

  modport master (
    output start, sub_opcode, div_lhs, div_rhs,
    input  busy, done, div_result
  );

  modport slave (
    input  start, sub_opcode, div_lhs, div_rhs,
    output busy, done, div_result
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// 32 iteration steps on operand magnitudes, then a sign fix-up cycle.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  bus
);
  localparam logic [4:0] OP_DIV  = 5'b11000;
  localparam logic [4:0] OP_DIVU = 5'b11110;
  localparam logic [4:0] OP_REM  = 5'b10000;
  localparam logic [4:0] OP_REMU = 5'b10111;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_t;

  state_t           state_r;
  logic [5:0]       count_r;
  logic [4:0]       op_r;
  logic             neg_quo_r;
  logic             neg_rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rem_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;

  logic             op_valid_s;
  logic             op_signed_s;
  logic [WIDTH-1:0] lhs_mag_s;
  logic [WIDTH-1:0] rhs_mag_s;
  logic             div_zero_s;
  logic             overflow_s;
  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] fin_val_s;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // Opcode decode of the incoming request.
  always_comb begin
    op_valid_s  = 1'b0;
    op_signed_s = 1'b0;
    case (bus.sub_opcode)
      OP_DIV, OP_REM: begin
        op_valid_s  = 1'b1;
        op_signed_s = 1'b1;
      end
      OP_DIVU, OP_REMU: begin
        op_valid_s  = 1'b1;
        op_signed_s = 1'b0;
      end
      default: begin
        op_valid_s  = 1'b0;
        op_signed_s = 1'b0;
      end
    endcase
  end

  assign lhs_mag_s  = magnitude(bus.div_lhs, op_signed_s);
  assign rhs_mag_s  = magnitude(bus.div_rhs, op_signed_s);
  assign div_zero_s = (bus.div_rhs == ZERO);
  assign overflow_s = op_signed_s && (bus.div_lhs == MIN_NEG) && (bus.div_rhs == ALL_ONES);

  // One restoring step: shift {R,Q}, keep the trial difference when it is non-negative.
  always_comb begin
    r_shift_s = {rem_r, q_r[WIDTH-1]};
    trial_s   = r_shift_s - {1'b0, dvs_r};
    if (!trial_s[WIDTH]) begin
      rem_next_s = trial_s[WIDTH-1:0];
      q_next_s   = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = r_shift_s[WIDTH-1:0];
      q_next_s   = {q_r[WIDTH-2:0], 1'b0};
    end
  end

  // Result selection and sign fix-up for the FIN cycle.
  always_comb begin
    if ((op_r == OP_REM) || (op_r == OP_REMU)) begin
      fin_val_s = cond_negate(rem_r, neg_rem_r);
    end else begin
      fin_val_s = cond_negate(q_r, neg_quo_r);
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      count_r   <= 6'd0;
      op_r      <= 5'd0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dvs_r     <= ZERO;
      q_r       <= ZERO;
      rem_r     <= ZERO;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= ZERO;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && op_valid_s) begin
            op_r    <= bus.sub_opcode;
            dvs_r   <= rhs_mag_s;
            count_r <= 6'd0;
            busy_r  <= 1'b1;
            // Special cases preset both Q and R so FIN just picks one unmodified.
            if (div_zero_s) begin
              q_r       <= ALL_ONES;
              rem_r     <= bus.div_lhs;
              neg_quo_r <= 1'b0;
              neg_rem_r <= 1'b0;
              state_r   <= FIN;
            end else if (overflow_s) begin
              q_r       <= MIN_NEG;
              rem_r     <= ZERO;
              neg_quo_r <= 1'b0;
              neg_rem_r <= 1'b0;
              state_r   <= FIN;
            end else begin
              q_r       <= lhs_mag_s;
              rem_r     <= ZERO;
              neg_quo_r <= op_signed_s & (bus.div_lhs[WIDTH-1] ^ bus.div_rhs[WIDTH-1]);
              neg_rem_r <= op_signed_s & bus.div_lhs[WIDTH-1];
              state_r   <= CALC;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          q_r     <= q_next_s;
          rem_r   <= rem_next_s;
          count_r <= count_r + 6'd1;
          if (count_r == 6'd31) begin
            state_r <= FIN;
          end else begin
            state_r <= CALC;
          end
        end
        FIN: begin
          result_r <= fin_val_s;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          count_r  <= 6'd0;
          state_r  <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          count_r <= 6'd0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.div_result = result_r;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases plus randomized
// operations against an arithmetic reference model.
module tb_div_unit;
  localparam logic [4:0] OP_DIV  = 5'b11000;
  localparam logic [4:0] OP_DIVU = 5'b11110;
  localparam logic [4:0] OP_REM  = 5'b10000;
  localparam logic [4:0] OP_REMU = 5'b10111;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  div_unit_if #(.WIDTH(32)) bif ();
  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics straight from the ISA rules.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (ovf) return 32'h8000_0000;
        else return $signed(a) / $signed(b);
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        else if (ovf) return 32'd0;
        else return $signed(a) % $signed(b);
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else return a / b;
      end
      OP_REMU: begin
        if (b == 32'd0) return a;
        else return a % b;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Called at a negedge: holds start for one cycle, then scrambles the operands.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bif.start      = 1'b1;
    bif.sub_opcode = op;
    bif.div_lhs    = a;
    bif.div_rhs    = b;
    @(negedge clk);
    bif.start      = 1'b0;
    bif.sub_opcode = 5'($urandom);
    bif.div_lhs    = $urandom;
    bif.div_rhs    = $urandom;
  endtask

  // Waits (bounded) for done; lat counts cycles from the start cycle, starting at 1 on entry.
  task automatic wait_done(output logic [31:0] res, output int lat, output int busy_cycles,
                           output logic busy_at_done);
    lat         = 1;
    busy_cycles = 0;
    while (!bif.done && lat < 100) begin
      if (bif.busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    res          = bif.div_result;
    busy_at_done = bif.busy;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bif.start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.div_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
               bif.busy, bif.done, bif.div_result);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [4:0]  ops [14] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_REM, OP_DIVU, OP_DIVU, OP_REMU,
                              OP_DIV, OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV};
    logic [31:0] as  [14] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF,
                              32'h1234, 32'h1234, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000,
                              32'h8000_0000, 32'd5, 32'd0};
    logic [31:0] bs  [14] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'd3};
    logic [31:0] exp [14] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF,
                              32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                              32'd0, 32'd5, 32'd0};
    logic [31:0] res;
    int          lat, bc;
    logic        bd;
    for (int i = 0; i < 14; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(res, lat, bc, bd);
      n_checks++;
      if (res !== exp[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, res, exp[i]);
      end
      n_checks++;
      if (lat !== model_latency(ops[i], as[i], bs[i]) || bc !== lat - 1 || bd !== 1'b0) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: latency %0d busy %0d busy_at_done %b, required %0d %0d 0",
                 i, lat, bc, bd, model_latency(ops[i], as[i], bs[i]), model_latency(ops[i], as[i], bs[i]) - 1);
      end
      @(negedge clk);
      n_checks++;
      if (bif.done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_pulse[%0d]: done=%b after done cycle, required 0", i, bif.done);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  ops [4] = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    logic [4:0]  op;
    logic [31:0] a, b, res, exp;
    int          lat, bc;
    logic        bd;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 3)];
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp = model(op, a, b);
      issue(op, a, b);
      wait_done(res, lat, bc, bd);
      n_checks++;
      if (res !== exp || lat !== model_latency(op, a, b) || bd !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b %h/%h: got %h lat %0d busy_at_done %b, required %h lat %0d",
                 i, op, a, b, res, lat, bd, exp, model_latency(op, a, b));
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] res;
    int          lat, bc;
    logic        bd;
    issue(OP_DIVU, 32'd5000, 32'd7);
    repeat (5) @(negedge clk);
    bif.start      = 1'b1;
    bif.sub_opcode = OP_DIV;
    bif.div_lhs    = 32'd99;
    bif.div_rhs    = 32'd3;
    @(negedge clk);
    bif.start = 1'b0;
    wait_done(res, lat, bc, bd);
    n_checks++;
    if (res !== model(OP_DIVU, 32'd5000, 32'd7) || lat !== 28) begin
      n_fail++;
      $display("FAIL start_while_busy: got %h at %0d, required %h at 28",
               res, lat, model(OP_DIVU, 32'd5000, 32'd7));
    end
    @(negedge clk);
    n_checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_while_busy_queued: busy=%b done=%b, required 0 0", bif.busy, bif.done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          lat, bc;
    logic        bd;
    issue(OP_REMU, 32'd1001, 32'd10);
    wait_done(res, lat, bc, bd);
    n_checks++;
    if (res !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_first: got %h, required 00000001", res);
    end
    issue(OP_DIV, 32'hFFFF_FF00, 32'd16);
    wait_done(res, lat, bc, bd);
    n_checks++;
    if (res !== 32'hFFFF_FFF0 || lat !== 34) begin
      n_fail++;
      $display("FAIL b2b_second: got %h at %0d, required fffffff0 at 34", res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_opcode();
    int seen_busy, seen_done;
    seen_busy = 0;
    seen_done = 0;
    issue(5'b00001, 32'd100, 32'd7);
    for (int i = 0; i < 40; i++) begin
      if (bif.busy) seen_busy++;
      if (bif.done) seen_done++;
      @(negedge clk);
    end
    n_checks++;
    if (seen_busy !== 0 || seen_done !== 0) begin
      n_fail++;
      $display("FAIL bad_opcode: busy cycles %0d done cycles %0d, required 0 0", seen_busy, seen_done);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int          lat, bc, seen_done;
    logic        bd;
    issue(OP_DIV, 32'd12345, 32'd11);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.div_result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h, required 0 0 00000000",
               bif.busy, bif.done, bif.div_result);
    end
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bif.done || bif.busy) seen_done++;
      @(negedge clk);
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL reset_discard: %0d cycles of busy/done after reset, required 0", seen_done);
    end
    issue(OP_DIVU, 32'd1000, 32'd10);
    wait_done(res, lat, bc, bd);
    n_checks++;
    if (res !== 32'd100 || lat !== 34) begin
      n_fail++;
      $display("FAIL after_reset: got %h at %0d, required 00000064 at 34", res, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_with_start();
    int seen;
    seen = 0;
    bif.start      = 1'b1;
    bif.sub_opcode = OP_DIVU;
    bif.div_lhs    = 32'd50;
    bif.div_rhs    = 32'd5;
    reset          = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bif.done || bif.busy) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_with_start: %0d busy/done cycles, required 0", seen);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bif.start      = 1'b0;
    bif.sub_opcode = 5'd0;
    bif.div_lhs    = 32'd0;
    bif.div_rhs    = 32'd0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_bad_opcode();
    test_reset_mid_op();
    test_reset_with_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
